// File: rtl/alien_bomb.sv
// Enemy bomb: seeks a random column holding a live alien, drops one bomb from
// just below the lowest alien, and pulses o_player_hit when it lands on the ship.
module alien_bomb #(
  parameter int unsigned TICK_CYCLES    = 2500000,
  parameter int unsigned COOLDOWN_TICKS = 8,
  parameter int unsigned SHIP_ROW       = 13,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5,
  parameter int unsigned MAX_TRIES      = 32
) (
  input  logic       i_clk_25MHz,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [4:0] i_ship_x,
  input  logic       i_cancel,
  input  logic       i_query_valid,
  input  logic [3:0] i_query_y,
  output logic [4:0] o_query_col,
  output logic [4:0] o_bomb_x,
  output logic [3:0] o_bomb_y,
  output logic       o_bomb_active,
  output logic       o_player_hit
);

  localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned CoolW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam int unsigned TryW  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;

  localparam logic [TickW-1:0] TickLast   = TickW'(TICK_CYCLES - 1);
  localparam logic [CoolW-1:0] CoolReload = CoolW'(COOLDOWN_TICKS);
  localparam logic [TryW-1:0]  TryLast    = TryW'(MAX_TRIES - 1);
  localparam logic [3:0]       ShipRow    = 4'(SHIP_ROW);
  // Highest alien row a bomb may spawn under without starting on/under the ship.
  localparam logic [3:0]       SpawnMaxY  = 4'(SHIP_ROW - 2);
  localparam logic [3:0]       ParkY      = 4'd15;
  localparam logic [3:0]       LastRow    = 4'd14;

  typedef enum logic [1:0] {
    StCooldown,
    StSeek,
    StFalling
  } state_e;

  state_e           state_q, state_d;
  logic [TickW-1:0] tick_cnt_q;
  logic             tick;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [CoolW-1:0] cool_q, cool_d;
  logic [TryW-1:0]  tries_q, tries_d;
  logic [4:0]       bomb_x_q, bomb_x_d;
  logic [3:0]       bomb_y_q, bomb_y_d;
  logic             active_q, active_d;
  logic             hit_q, hit_d;
  logic             despawn;

  assign tick        = (tick_cnt_q == TickLast);
  assign o_query_col = lfsr_q[4:0];

  assign o_bomb_x      = bomb_x_q;
  assign o_bomb_y      = bomb_y_q;
  assign o_bomb_active = active_q;
  assign o_player_hit  = hit_q;

  // Free-running movement tick divider.
  always_ff @(posedge i_clk_25MHz) begin
    if (i_reset) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // Next-state logic: cooldown, column seek and falling bomb.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cool_d   = cool_q;
    tries_d  = tries_q;
    bomb_x_d = bomb_x_q;
    bomb_y_d = bomb_y_q;
    active_d = active_q;
    hit_d    = 1'b0;
    despawn  = 1'b0;

    unique case (state_q)
      StCooldown: begin
        if (i_enable) begin
          if (cool_q == '0) begin
            state_d = StSeek;
            tries_d = '0;
          end else if (tick) begin
            cool_d = cool_q - 1'b1;
          end
        end
      end

      StSeek: begin
        // The LFSR steps every seek cycle so each query sees a new column.
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        if (!i_enable) begin
          despawn = 1'b1;
        end else if (i_query_valid && (i_query_y <= SpawnMaxY)) begin
          bomb_x_d = lfsr_q[4:0];
          bomb_y_d = i_query_y + 4'd1;
          active_d = 1'b1;
          state_d  = StFalling;
        end else begin
          tries_d = tries_q + 1'b1;
          if (tries_q == TryLast) begin
            despawn = 1'b1;
          end
        end
      end

      StFalling: begin
        if (i_cancel) begin
          despawn = 1'b1;
        end else if (tick && i_enable) begin
          if (((bomb_y_q + 4'd1) == ShipRow) && (bomb_x_q == i_ship_x)) begin
            hit_d   = 1'b1;
            despawn = 1'b1;
          end else if (bomb_y_q == LastRow) begin
            despawn = 1'b1;
          end else begin
            bomb_y_d = bomb_y_q + 4'd1;
          end
        end
      end

      default: begin
        despawn = 1'b1;
      end
    endcase

    // Parking the bomb always restarts the cooldown.
    if (despawn) begin
      bomb_x_d = '0;
      bomb_y_d = ParkY;
      active_d = 1'b0;
      cool_d   = CoolReload;
      state_d  = StCooldown;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk_25MHz) begin
    if (i_reset) begin
      state_q  <= StCooldown;
      lfsr_q   <= LFSR_SEED;
      cool_q   <= CoolReload;
      tries_q  <= '0;
      bomb_x_q <= '0;
      bomb_y_q <= ParkY;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cool_q   <= cool_d;
      tries_q  <= tries_d;
      bomb_x_q <= bomb_x_d;
      bomb_y_q <= bomb_y_d;
      active_q <= active_d;
      hit_q    <= hit_d;
    end
  end

endmodule

// File: tb/tb_alien_bomb.sv
// Scoreboarded bench for alien_bomb: stimulus queues expected spawn/hit/despawn
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_alien_bomb;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_enable;
  logic [4:0] i_ship_x;
  logic       i_cancel;
  logic       i_query_valid;
  logic [3:0] i_query_y;
  logic [4:0] o_query_col;
  logic [4:0] o_bomb_x;
  logic [3:0] o_bomb_y;
  logic       o_bomb_active;
  logic       o_player_hit;

  // Alien grid model: which columns have a live alien and its lowest row.
  logic [31:0] tbl_valid;
  logic [3:0]  tbl_y [32];

  assign i_query_valid = tbl_valid[o_query_col];
  assign i_query_y     = tbl_y[o_query_col];

  always #20 clk = ~clk;

  alien_bomb #(
    .TICK_CYCLES   (4),
    .COOLDOWN_TICKS(2),
    .SHIP_ROW      (13),
    .LFSR_SEED     (8'hA5),
    .MAX_TRIES     (32)
  ) dut (
    .i_clk_25MHz  (clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_ship_x     (i_ship_x),
    .i_cancel     (i_cancel),
    .i_query_valid(i_query_valid),
    .i_query_y    (i_query_y),
    .o_query_col  (o_query_col),
    .o_bomb_x     (o_bomb_x),
    .o_bomb_y     (o_bomb_y),
    .o_bomb_active(o_bomb_active),
    .o_player_hit (o_player_hit)
  );

  typedef enum logic [1:0] {EvSpawn, EvHit, EvDespawn} ev_kind_e;
  typedef struct packed {
    ev_kind_e   kind;
    logic [4:0] x;
    logic [3:0] y;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push(input ev_kind_e k, input logic [4:0] x, input logic [3:0] y);
    ev_t e;
    e.kind = k;
    e.x    = x;
    e.y    = y;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_active(input logic lvl, input int budget, input string name);
    int n = 0;
    while (o_bomb_active !== lvl && n < budget) begin
      step();
      n++;
    end
    check(name, int'(o_bomb_active == lvl), 1);
  endtask

  task automatic wait_y(input logic [3:0] y, input int budget, input string name);
    int n = 0;
    while (o_bomb_y !== y && n < budget) begin
      step();
      n++;
    end
    check(name, int'(o_bomb_y == y), 1);
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Monitor: classify output changes into events and compare with the scoreboard.
  initial begin
    logic prev_active;
    logic got_ev;
    ev_t  got;
    ev_t  exp;
    prev_active = 1'b0;
    forever begin
      @(negedge clk);
      if (!i_reset) begin
        got_ev = 1'b0;
        got    = '0;
        if (o_player_hit) begin
          got    = {EvHit, o_bomb_x, o_bomb_y};
          got_ev = 1'b1;
          check("hit_clears_active", int'(o_bomb_active), 0);
        end else if (prev_active && !o_bomb_active) begin
          got    = {EvDespawn, o_bomb_x, o_bomb_y};
          got_ev = 1'b1;
        end else if (!prev_active && o_bomb_active) begin
          got    = {EvSpawn, o_bomb_x, o_bomb_y};
          got_ev = 1'b1;
        end
        if (o_bomb_active) check("active_y_not_parked", int'(o_bomb_y != 4'd15), 1);
        if (got_ev) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got kind %0d x %0d y %0d, expected none",
                     int'(got.kind), got.x, got.y);
          end else begin
            exp = sb.pop_front();
            check("ev_kind", int'(got.kind), int'(exp.kind));
            check("ev_x", got.x, exp.x);
            check("ev_y", got.y, exp.y);
          end
        end
      end
      prev_active = o_bomb_active;
    end
  end

  initial begin
    int         n;
    logic [3:0] max_y;
    logic [4:0] prev_col;
    int         run;
    bit         started;
    logic [7:0] exp_l;

    i_reset   = 1'b1;
    i_enable  = 1'b1;
    i_cancel  = 1'b0;
    i_ship_x  = 5'd10;
    tbl_valid = '0;
    for (int i = 0; i < 32; i++) tbl_y[i] = 4'd0;
    tbl_valid[10] = 1'b1;
    tbl_y[10]     = 4'd3;

    repeat (3) step();
    check("rst_x", o_bomb_x, 0);
    check("rst_y", o_bomb_y, 15);
    check("rst_active", o_bomb_active, 0);
    check("rst_hit", o_player_hit, 0);
    check("rst_query_col", o_query_col, 5);

    // Bomb 1: col 5 misses, col 10 spawns at row 4 and lands on the ship.
    push(EvSpawn, 5'd10, 4'd4);
    push(EvHit, 5'd0, 4'd15);
    i_reset = 1'b0;
    n = 0;
    while (o_query_col == 5'd5 && n < 50) begin
      step();
      n++;
    end
    check("seek_second_query_cycle", n, 10);
    check("seek_second_query_col", o_query_col, 10);
    check("seek_not_active_yet", o_bomb_active, 0);
    wait_active(1'b1, 4, "b1_spawn");
    check("b1_spawn_y", o_bomb_y, 4);
    wait_active(1'b0, 100, "b1_despawn");
    check("b1_park_y", o_bomb_y, 15);
    check("b1_park_x", o_bomb_x, 0);
    step();
    check("b1_hit_one_cycle", o_player_hit, 0);

    // Bomb 2: col 21 misses, col 10 spawns; ship one column over, bomb exits at row 14.
    push(EvSpawn, 5'd10, 4'd4);
    push(EvDespawn, 5'd0, 4'd15);
    i_ship_x = 5'd11;
    wait_active(1'b1, 100, "b2_spawn");
    max_y = o_bomb_y;
    n = 0;
    while (o_bomb_active && n < 100) begin
      step();
      n++;
      if (o_bomb_active && o_bomb_y > max_y) max_y = o_bomb_y;
    end
    check("b2_max_row", max_y, 14);
    check("b2_gone", o_bomb_active, 0);

    // Bomb 3: cancel coincides with the tick that would hit the ship.
    tbl_valid[20] = 1'b1;
    tbl_y[20]     = 4'd3;
    i_ship_x      = 5'd20;
    push(EvSpawn, 5'd20, 4'd4);
    push(EvDespawn, 5'd0, 4'd15);
    wait_active(1'b1, 100, "b3_spawn");
    wait_y(4'd12, 100, "b3_reach_12");
    repeat (3) step();
    i_cancel = 1'b1;
    step();
    i_cancel = 1'b0;
    check("b3_cancel_active", o_bomb_active, 0);
    check("b3_cancel_y", o_bomb_y, 15);

    // Bomb 4: enable low freezes the fall for three ticks.
    tbl_valid[9] = 1'b1;
    tbl_y[9]     = 4'd3;
    i_ship_x     = 5'd0;
    push(EvSpawn, 5'd9, 4'd4);
    push(EvDespawn, 5'd0, 4'd15);
    wait_active(1'b1, 100, "b4_spawn");
    wait_y(4'd6, 100, "b4_reach_6");
    i_enable = 1'b0;
    repeat (12) step();
    check("b4_hold_y", o_bomb_y, 6);
    check("b4_hold_active", o_bomb_active, 1);
    i_enable = 1'b1;
    wait_active(1'b0, 100, "b4_despawn");

    // Exhaustion: only col 19 has an alien, at row 12, which must be rejected.
    tbl_valid     = '0;
    tbl_valid[19] = 1'b1;
    tbl_y[19]     = 4'd12;
    check("b5_cooldown_col", o_query_col, 19);
    exp_l = 8'h53;
    for (int i = 0; i < 32; i++) exp_l = lfsr_next(exp_l);
    prev_col = o_query_col;
    run      = 0;
    started  = 1'b0;
    n        = 0;
    while (!(started && run == 5) && n < 300) begin
      step();
      n++;
      if (o_query_col != prev_col) begin
        started = 1'b1;
        run     = 0;
      end else begin
        run++;
      end
      prev_col = o_query_col;
    end
    check("b5_exhaust_reached_cooldown", int'(started && run == 5), 1);
    check("b5_exhaust_col", o_query_col, exp_l[4:0]);
    check("b5_no_bomb", o_bomb_active, 0);

    repeat (4) step();
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
